axi_burst_addr_gen: RTL and testbench
=====================================

AXI_BURST_ADDR_GEN -- requirements
Module: axi_burst_addr_gen

Interface
REQ-001 Parameter DW, default 32: data bus width in bits; SHALL be 8, 16, 32, 64, 128 or 256.
REQ-002 Parameter AW, default 16: address width in bits; SHALL be at least 8.
REQ-003 Derived DSZ = log2(DW/8), the bus size code. NB = DW/8, the byte lanes.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 i_clk  input  1  clock; all state updates on rising edge.
REQ-006 i_rst_n  input  1  synchronous active-low reset.
REQ-007 i_cmd_valid  input  1  burst command valid.
REQ-008 o_cmd_ready  output  1  command accepted when valid&ready.
REQ-009 i_cmd_addr  input  AW  start byte address.
REQ-010 i_cmd_len  input  8  AXI len (beats-1).
REQ-011 i_cmd_size  input  3  AXI size (bytes = 1<<size).
REQ-012 i_cmd_burst  input  2  00 FIXED, 01 INCR, 10 WRAP.
REQ-013 o_beat_valid  output  1  beat address valid.
REQ-014 i_beat_ready  input  1  beat consumed when valid&ready.
REQ-015 o_beat_addr  output  AW  beat byte address.
REQ-016 o_beat_strb  output  NB  active byte lanes of beat.
REQ-017 o_beat_last  output  1  final beat of burst.
REQ-018 o_beat_idx  output  8  beat number, 0..len.
REQ-019 o_busy  output  1  burst in progress.

Function
REQ-020 The FSM SHALL have two states: IDLE and BURST. o_cmd_ready = (state==IDLE); o_busy = o_beat_valid = (state==BURST).
REQ-021 IDLE->BURST on cmd handshake; command fields registered; first beat valid the following cycle with o_beat_addr = i_cmd_addr unmodified and o_beat_idx = 0.
REQ-022 BURST->IDLE on handshake of the beat with o_beat_idx==len; o_cmd_ready rises the next cycle. There SHALL be no back-to-back overlap.
REQ-023 While o_beat_valid & !i_beat_ready, all beat outputs SHALL hold stable.
REQ-024 Effective size esz = min(i_cmd_size, DSZ): oversize requests are clamped, with no error.
REQ-025 Next address on beat handshake, FIXED: unchanged.
REQ-026 Next address, INCR: (addr aligned down to 1<<esz) + (1<<esz), full AW-bit modulo arithmetic.
REQ-027 WRAP with len in {1,3,7,15}: wrap span W = (len+1)<<esz; next = (cur & ~(W-1)) | (incr_result & (W-1)).
REQ-028 WRAP with any other len, and burst code 11, SHALL be treated as INCR.
REQ-029 4KB rule (AW>12 only): bits AW-1:12 of every next address SHALL equal those of the current address; carry out of bit 11 is discarded.
REQ-030 o_beat_strb: lanes from o_beat_addr[DSZ-1:0] up to the end of the 1<<esz-byte aligned container are set. An unaligned first beat sets only the upper part. For DW=8, strb = 1.
REQ-031 o_beat_last = (o_beat_idx == registered len). For len=0, the first beat is last.
REQ-032 o_beat_idx SHALL increment by 1 per beat handshake and SHALL never exceed len.

Reset
REQ-033 When i_rst_n=0 at a clock edge: state=IDLE, o_cmd_ready=1, o_beat_valid=0, o_busy=0, o_beat_addr=0, o_beat_strb=0, o_beat_last=0, o_beat_idx=0.
REQ-034 Reset mid-burst SHALL abort the burst with no further beats; the next command after reset release SHALL be handled normally.

Verification (DW=32, AW=16, i_beat_ready=1 unless stated)
REQ-035 INCR addr 0x0003 len 3 size 2 -> 0x0003/strb 1000, 0x0004/1111, 0x0008/1111, 0x000C/1111 last; o_cmd_ready high the cycle after.
REQ-036 WRAP addr 0x0034 len 3 size 2 -> 0x0034, 0x0038, 0x003C, 0x0030 last; all strb 1111.
REQ-037 INCR addr 0x0FF8 len 3 size 2 -> 0x0FF8, 0x0FFC, 0x0000, 0x0004 last (4KB page held).
REQ-038 FIXED addr 0x0011 len 2 size 0 -> three beats 0x0011, strb 0010, last on idx 2; size 3 with INCR clamps to 4-byte steps.
REQ-039 i_beat_ready low 3 cycles at idx 1 -> outputs frozen, then resume. i_rst_n low at idx 2 -> o_beat_valid=0 and o_cmd_ready=1 next cycle.

Source files
------------

// File: rtl/axi_burst_addr_gen.sv
// AXI burst address generator: accepts one burst command and emits per-beat
// byte addresses, lane strobes, beat index and last flag (FIXED/INCR/WRAP, 4KB-safe).
module axi_burst_addr_gen #(
    parameter int DW = 32,
    parameter int AW = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic [AW-1:0]   i_cmd_addr,
    input  logic [7:0]      i_cmd_len,
    input  logic [2:0]      i_cmd_size,
    input  logic [1:0]      i_cmd_burst,
    output logic            o_beat_valid,
    input  logic            i_beat_ready,
    output logic [AW-1:0]   o_beat_addr,
    output logic [DW/8-1:0] o_beat_strb,
    output logic            o_beat_last,
    output logic [7:0]      o_beat_idx,
    output logic            o_busy
);

    localparam int NB  = DW / 8;
    localparam int DSZ = $clog2(NB);
    // Address bits above the 4KB page; all ones-free when AW <= 12.
    localparam logic [AW-1:0] PAGE_MASK = ~AW'(4095);

    typedef enum logic {IDLE, BURST} state_t;
    typedef enum logic [1:0] {M_FIXED, M_INCR, M_WRAP} mode_t;

    state_t        state, state_next;
    mode_t         mode_r, cmd_mode;
    logic [AW-1:0] addr_r, next_addr, step, aligned, incr_addr, wrap_mask, cand;
    logic [AW-1:0] lane_lo, lane_hi;
    logic [7:0]    idx_r, len_r;
    logic [2:0]    esz_r, cmd_esz;
    logic [8:0]    wrap_beats;
    logic          cmd_fire, beat_fire, last_beat, wrap_len_ok;

    assign cmd_fire  = i_cmd_valid && o_cmd_ready;
    assign beat_fire = o_beat_valid && i_beat_ready;
    assign last_beat = (idx_r == len_r);

    // Command decode: clamp oversize requests, demote illegal WRAP and code 11 to INCR.
    assign cmd_esz     = (i_cmd_size > 3'(DSZ)) ? 3'(DSZ) : i_cmd_size;
    assign wrap_len_ok = (i_cmd_len == 8'd1) || (i_cmd_len == 8'd3) ||
                         (i_cmd_len == 8'd7) || (i_cmd_len == 8'd15);
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cmd_mode = M_INCR;
        if (i_cmd_burst == 2'b00)
            cmd_mode = M_FIXED;
        else if (i_cmd_burst == 2'b10 && wrap_len_ok)
            cmd_mode = M_WRAP;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire) state_next = BURST;
            BURST:   if (beat_fire && last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next beat address; wrap span fits in 9 bits before the size shift.
    always_comb begin
        step       = AW'(1) << esz_r;
        aligned    = addr_r & ~(step - AW'(1));
        incr_addr  = aligned + step;
        wrap_beats = {1'b0, len_r} + 9'd1;
        wrap_mask  = (AW'(wrap_beats) << esz_r) - AW'(1);
        case (mode_r)
            M_FIXED: cand = addr_r;
            M_WRAP:  cand = (addr_r & ~wrap_mask) | (incr_addr & wrap_mask);
            default: cand = incr_addr;
        endcase
        next_addr = (addr_r & PAGE_MASK) | (cand & ~PAGE_MASK);
    end

    // Burst context and beat counters.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            addr_r <= '0;
            idx_r  <= '0;
            len_r  <= '0;
            esz_r  <= '0;
            mode_r <= M_FIXED;
        end else if (cmd_fire) begin
            addr_r <= i_cmd_addr;
            idx_r  <= '0;
            len_r  <= i_cmd_len;
            esz_r  <= cmd_esz;
            mode_r <= cmd_mode;
        end else if (beat_fire && !last_beat) begin
            addr_r <= next_addr;
            idx_r  <= idx_r + 8'd1;
        end
    end

    // Output logic: strobe covers the current lane up to the end of its size container.
    always_comb begin
        o_cmd_ready  = (state == IDLE);
        o_busy       = (state == BURST);
        o_beat_valid = (state == BURST);
        o_beat_addr  = addr_r;
        o_beat_idx   = idx_r;
        o_beat_last  = o_busy && last_beat;
        lane_lo      = addr_r & AW'(NB - 1);
        lane_hi      = (lane_lo & ~(step - AW'(1))) + step - AW'(1);
        o_beat_strb  = '0;
        for (int i = 0; i < NB; i++)
            if (o_busy && AW'(i) >= lane_lo && AW'(i) <= lane_hi)
                o_beat_strb[i] = 1'b1;
    end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed bench for axi_burst_addr_gen (DW=32, AW=16) with hand-computed beat sequences.
module tb_axi_burst_addr_gen;

    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [2:0]    cmd_size;
    logic [1:0]    cmd_burst;
    logic          beat_valid;
    logic          beat_ready;
    logic [AW-1:0] beat_addr;
    logic [3:0]    beat_strb;
    logic          beat_last;
    logic [7:0]    beat_idx;
    logic          busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_burst_addr_gen #(.DW(DW), .AW(AW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_addr   (cmd_addr),
        .i_cmd_len    (cmd_len),
        .i_cmd_size   (cmd_size),
        .i_cmd_burst  (cmd_burst),
        .o_beat_valid (beat_valid),
        .i_beat_ready (beat_ready),
        .o_beat_addr  (beat_addr),
        .o_beat_strb  (beat_strb),
        .o_beat_last  (beat_last),
        .o_beat_idx   (beat_idx),
        .o_busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] a, input logic [7:0] l,
                            input logic [2:0] s, input logic [1:0] b);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
        cmd_burst = b;
        cmd_valid = 1'b1;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    // Check the visible beat, then consume it (beat_ready assumed high).
    task automatic beat(input string tag, input logic [15:0] a, input logic [3:0] s,
                        input logic [7:0] i, input logic l);
        check({tag, "_valid"}, 32'(beat_valid), 32'd1);
        check({tag, "_busy"},  32'(busy),       32'd1);
        check({tag, "_cready"}, 32'(cmd_ready), 32'd0);
        check({tag, "_addr"},  32'(beat_addr),  32'(a));
        check({tag, "_strb"},  32'(beat_strb),  32'(s));
        check({tag, "_idx"},   32'(beat_idx),   32'(i));
        check({tag, "_last"},  32'(beat_last),  32'(l));
        step();
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_cready"}, 32'(cmd_ready),  32'd1);
        check({tag, "_valid"},  32'(beat_valid), 32'd0);
        check({tag, "_busy"},   32'(busy),       32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        cmd_size   = '0;
        cmd_burst  = '0;
        beat_ready = 1'b1;
        step();
        step();
        idle_check("rst");
        check("rst_addr", 32'(beat_addr), 32'd0);
        check("rst_strb", 32'(beat_strb), 32'd0);
        check("rst_last", 32'(beat_last), 32'd0);
        check("rst_idx",  32'(beat_idx),  32'd0);
        rst_n = 1'b1;
        step();

        // INCR, unaligned start.
        send_cmd(16'h0003, 8'd3, 3'd2, 2'b01);
        beat("incr0", 16'h0003, 4'b1000, 8'd0, 1'b0);
        beat("incr1", 16'h0004, 4'b1111, 8'd1, 1'b0);
        beat("incr2", 16'h0008, 4'b1111, 8'd2, 1'b0);
        beat("incr3", 16'h000C, 4'b1111, 8'd3, 1'b1);
        idle_check("incr_done");

        // WRAP over a 16-byte span.
        send_cmd(16'h0034, 8'd3, 3'd2, 2'b10);
        beat("wrap0", 16'h0034, 4'b1111, 8'd0, 1'b0);
        beat("wrap1", 16'h0038, 4'b1111, 8'd1, 1'b0);
        beat("wrap2", 16'h003C, 4'b1111, 8'd2, 1'b0);
        beat("wrap3", 16'h0030, 4'b1111, 8'd3, 1'b1);
        idle_check("wrap_done");

        // INCR crossing 4KB: page bits held.
        send_cmd(16'h0FF8, 8'd3, 3'd2, 2'b01);
        beat("pg0", 16'h0FF8, 4'b1111, 8'd0, 1'b0);
        beat("pg1", 16'h0FFC, 4'b1111, 8'd1, 1'b0);
        beat("pg2", 16'h0000, 4'b1111, 8'd2, 1'b0);
        beat("pg3", 16'h0004, 4'b1111, 8'd3, 1'b1);

        // FIXED byte bursts.
        send_cmd(16'h0011, 8'd2, 3'd0, 2'b00);
        beat("fix0", 16'h0011, 4'b0010, 8'd0, 1'b0);
        beat("fix1", 16'h0011, 4'b0010, 8'd1, 1'b0);
        beat("fix2", 16'h0011, 4'b0010, 8'd2, 1'b1);

        // Oversize INCR clamps to 4-byte steps.
        send_cmd(16'h0010, 8'd1, 3'd3, 2'b01);
        beat("clamp0", 16'h0010, 4'b1111, 8'd0, 1'b0);
        beat("clamp1", 16'h0014, 4'b1111, 8'd1, 1'b1);

        // len=0: first beat is last.
        send_cmd(16'h0020, 8'd0, 3'd2, 2'b01);
        beat("len0", 16'h0020, 4'b1111, 8'd0, 1'b1);
        idle_check("len0_done");

        // WRAP with len=2 behaves as INCR; code 11 too.
        send_cmd(16'h003C, 8'd2, 3'd2, 2'b10);
        beat("wbad0", 16'h003C, 4'b1111, 8'd0, 1'b0);
        beat("wbad1", 16'h0040, 4'b1111, 8'd1, 1'b0);
        beat("wbad2", 16'h0044, 4'b1111, 8'd2, 1'b1);
        send_cmd(16'h0102, 8'd1, 3'd1, 2'b11);
        beat("b11_0", 16'h0102, 4'b1100, 8'd0, 1'b0);
        beat("b11_1", 16'h0104, 4'b0011, 8'd1, 1'b1);

        // Backpressure at idx 1, then reset at idx 2.
        send_cmd(16'h0100, 8'd3, 3'd2, 2'b01);
        beat("bp0", 16'h0100, 4'b1111, 8'd0, 1'b0);
        beat_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_hold_valid", 32'(beat_valid), 32'd1);
            check("bp_hold_addr",  32'(beat_addr),  32'h0104);
            check("bp_hold_idx",   32'(beat_idx),   32'd1);
            check("bp_hold_strb",  32'(beat_strb),  32'hF);
        end
        beat_ready = 1'b1;
        beat("bp1", 16'h0104, 4'b1111, 8'd1, 1'b0);
        check("bp2_addr", 32'(beat_addr), 32'h0108);
        check("bp2_idx",  32'(beat_idx),  32'd2);
        rst_n = 1'b0;
        step();
        idle_check("abort");
        check("abort_idx", 32'(beat_idx), 32'd0);
        rst_n = 1'b1;
        step();
        idle_check("abort_idle");

        // Normal command after reset release.
        send_cmd(16'h0200, 8'd1, 3'd1, 2'b01);
        beat("post0", 16'h0200, 4'b0011, 8'd0, 1'b0);
        beat("post1", 16'h0202, 4'b1100, 8'd1, 1'b1);
        idle_check("post_done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
